// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO feeding an external combinational 16-bit ALU,
// with a registered result stage and valid/ready flow control on both sides.
module alu_cmd_queue #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_i0,
    output logic [WIDTH-1:0] alu_i1,
    input  logic [WIDTH-1:0] alu_o,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_o,
    output logic             res_cout,
    output logic [1:0]       res_op,
    output logic [AW:0]      count
);

    localparam int unsigned EW = 2 + 2 * WIDTH;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    // Entry layout: {op, a, b}
    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_o_q, res_o_d;
    logic             res_cout_q, res_cout_d;
    logic [1:0]       res_op_q, res_op_d;

    logic             empty;
    logic             push;
    logic             pop;
    logic             can_load;
    logic [EW-1:0]    head;

    // Handshake decode and head-of-queue drive towards the ALU
    always_comb begin
        empty    = (count_q == '0);
        in_ready = (count_q < FULL_COUNT);
        push     = in_valid & in_ready;
        can_load = ~res_valid_q | res_ready;
        pop      = ~empty & can_load;
        head     = mem_q[rd_ptr_q];
        if (empty) begin
            alu_op = '0;
            alu_i0 = '0;
            alu_i1 = '0;
        end else begin
            alu_op = head[EW-1 -: 2];
            alu_i0 = head[2*WIDTH-1 -: WIDTH];
            alu_i1 = head[WIDTH-1:0];
        end
    end

    // Next-state for pointers, occupancy and the result stage
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        res_valid_d = res_valid_q;
        res_o_d     = res_o_q;
        res_cout_d  = res_cout_q;
        res_op_d    = res_op_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            res_valid_d = 1'b1;
            res_o_d     = alu_o;
            res_cout_d  = alu_cout;
            res_op_d    = alu_op;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    // Control and result registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_o_q     <= '0;
            res_cout_q  <= 1'b0;
            res_op_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_o_q     <= res_o_d;
            res_cout_q  <= res_cout_d;
            res_op_q    <= res_op_d;
        end
    end

    // FIFO storage write; contents are don't-care until pushed, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_op, in_a, in_b};
        end
    end

    assign res_valid = res_valid_q;
    assign res_o     = res_o_q;
    assign res_cout  = res_cout_q;
    assign res_op    = res_op_q;
    assign count     = count_q;

endmodule
